exec_result_queue: RTL

Buffers the per-cycle outputs of the execute stage (computed value, comparison bit, and the originating reservation-station cell) in a small in-order FIFO. It presents them one at a time to the common data bus (CDB) / writeback side under a valid/ready handshake. The queue decouples execute, which produces a result every cycle it is fed, from CDB arbitration, which may stall. It sits directly between the execute stage and the CDB arbiter.

---
 rtl/exec_result_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/exec_result_queue.sv
// In-order result queue between the execute stage and the CDB arbiter.
// Holds {value, comp_result, op} entries and hands the head out under valid/ready.
module exec_result_queue #(
  parameter int  DEPTH         = 4,
  parameter int  DATA_WIDTH    = 32,
  parameter type res_st_cell_t = logic [15:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_value,
  input  logic                         in_comp_result,
  input  res_st_cell_t                 in_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_value,
  output logic                         out_comp_result,
  output res_st_cell_t                 out_op,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] value;
    logic                  comp_result;
    res_st_cell_t          op;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             wr_entry_d;
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [PTR_W-1:0]   rp_q, rp_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  entry_t             head;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign in_ready  = !full;
  assign out_valid = !empty;

  always_comb begin
    push       = in_valid && in_ready && !flush;
    pop        = out_valid && out_ready && !flush;
    wr_entry_d = '{value: in_value, comp_result: in_comp_result, op: in_op};
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wp_d = wp_q + PTR_W'(1);
      if (pop)  rp_d = rp_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wp_q] <= wr_entry_d;
  end

  always_comb begin
    head = mem_q[rp_q];
    if (empty) head = '0;
    out_value       = head.value;
    out_comp_result = head.comp_result;
    out_op          = head.op;
  end

endmodule
